// File: rtl/pixel_sink.sv
// Painter-to-framebuffer bridge: edge-detects write strobes, range-checks and buffers pixels,
// then drains them to memory through a ready/valid write port, preserving capture order.
module pixel_sink #(
    parameter int unsigned SCR_WIDTH  = 160,
    parameter int unsigned SCR_HEIGHT = 120,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        Clck,
    input  logic        Reset,
    input  logic [7:0]  paint_x_co,
    input  logic [6:0]  paint_y_co,
    input  logic [2:0]  color,
    input  logic        print_enable,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic [2:0]  fifo_level,
    output logic        overflow,
    output logic [7:0]  drop_count,
    output logic        busy
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned EntW = 18;

    typedef enum logic [0:0] {StIdle, StWrite} state_e;

    state_e            state_q;
    logic              pe_q;
    logic              cap_valid_q;
    logic [14:0]       cap_addr_q;
    logic [2:0]        cap_color_q;
    logic [EntW-1:0]   fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [CntW-1:0]   count_q, count_d;
    logic [14:0]       mem_addr_q;
    logic [2:0]        mem_data_q;
    logic              mem_we_q;
    logic              overflow_q;
    logic [7:0]        drop_q;

    logic              capture, in_range, pop, full, push, ovf_drop, oor_drop;
    logic [14:0]       pix_addr;

    always_comb begin
        capture  = print_enable && !pe_q;
        in_range = (32'(paint_x_co) < SCR_WIDTH) && (32'(paint_y_co) < SCR_HEIGHT);
        pix_addr = 15'(32'(paint_y_co) * SCR_WIDTH + 32'(paint_x_co));
        pop      = (state_q == StWrite) && mem_we_q && mem_ready;
        full     = (count_q == CntW'(FIFO_DEPTH));
        // A full FIFO can still accept when the head leaves in the same cycle.
        push     = cap_valid_q && (!full || pop);
        ovf_drop = cap_valid_q && full && !pop;
        oor_drop = capture && !in_range;
        rd_nxt   = rd_ptr_q + PtrW'(1);
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            pe_q        <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_addr_q  <= '0;
            cap_color_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            drop_q      <= '0;
        end else begin
            pe_q        <= print_enable;
            cap_valid_q <= capture && in_range;
            if (capture) begin
                cap_addr_q  <= pix_addr;
                cap_color_q <= color;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_nxt;
            end
            count_q <= count_d;
            if (ovf_drop) begin
                overflow_q <= 1'b1;
            end
            if ((oor_drop || ovf_drop) && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge Clck) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {cap_addr_q, cap_color_q};
        end
    end

    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            state_q    <= StIdle;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    mem_we_q <= 1'b0;
                    if (count_q != '0) begin
                        {mem_addr_q, mem_data_q} <= fifo_q[rd_ptr_q];
                        mem_we_q                 <= 1'b1;
                        state_q                  <= StWrite;
                    end
                end
                StWrite: begin
                    if (mem_ready) begin
                        // Entry still queued behind the head: present it with no idle gap.
                        if (count_q > CntW'(1)) begin
                            {mem_addr_q, mem_data_q} <= fifo_q[rd_nxt];
                            mem_we_q                 <= 1'b1;
                        end else begin
                            mem_we_q <= 1'b0;
                            state_q  <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_we     = mem_we_q;
    assign fifo_level = 3'(count_q);
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign busy       = (count_q != '0) || mem_we_q;

endmodule

// File: tb/tb_pixel_sink.sv
// Directed self-checking bench for pixel_sink: single write, backpressure, overflow,
// bounds, reset behaviour and drop-counter saturation.
module tb_pixel_sink;

    logic        Clck;
    logic        Reset;
    logic [7:0]  paint_x_co;
    logic [6:0]  paint_y_co;
    logic [2:0]  color;
    logic        print_enable;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        mem_ready;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [14:0] acc_addr[$];
    int          acc_cyc[$];

    pixel_sink dut (
        .Clck         (Clck),
        .Reset        (Reset),
        .paint_x_co   (paint_x_co),
        .paint_y_co   (paint_y_co),
        .color        (color),
        .print_enable (print_enable),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_we       (mem_we),
        .mem_ready    (mem_ready),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .busy         (busy)
    );

    initial Clck = 1'b0;
    always #5 Clck = ~Clck;

    // Log every accepted write with the cycle it happened in.
    always @(posedge Clck) begin
        cyc <= cyc + 1;
        if (Reset && mem_we && mem_ready) begin
            acc_addr.push_back(mem_addr);
            acc_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] acc_at(input int i);
        if (i < acc_addr.size()) return 32'(acc_addr[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clck);
            #1;
        end
    endtask

    task automatic do_reset();
        print_enable = 1'b0;
        Reset        = 1'b0;
        tick(1);
        Reset = 1'b1;
        acc_addr.delete();
        acc_cyc.delete();
    endtask

    // One capture edge, then low for one edge so the next strobe re-arms.
    task automatic strobe(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        paint_x_co   = x;
        paint_y_co   = y;
        color        = c;
        print_enable = 1'b1;
        tick(1);
        print_enable = 1'b0;
        tick(1);
    endtask

    initial begin
        bit stable;
        bit seen;

        Reset        = 1'b0;
        print_enable = 1'b0;
        paint_x_co   = '0;
        paint_y_co   = '0;
        color        = '0;
        mem_ready    = 1'b1;
        tick(3);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drop", drop_count, 0);
        check("rst_busy", busy, 0);
        Reset = 1'b1;
        tick(2);

        // Single write with the strobe held for four edges.
        paint_x_co   = 8'd5;
        paint_y_co   = 7'd2;
        color        = 3'b110;
        print_enable = 1'b1;
        tick(1);
        check("single_n_level", fifo_level, 0);
        check("single_n_we", mem_we, 0);
        tick(1);
        check("single_n1_level", fifo_level, 1);
        check("single_n1_we", mem_we, 0);
        tick(1);
        check("single_n2_we", mem_we, 1);
        check("single_n2_addr", mem_addr, 325);
        check("single_n2_data", mem_data, 6);
        check("single_n2_busy", busy, 1);
        tick(1);
        print_enable = 1'b0;
        check("single_n3_we", mem_we, 0);
        check("single_n3_level", fifo_level, 0);
        tick(4);
        check("single_count", acc_addr.size(), 1);
        check("single_acc_addr", acc_at(0), 325);

        // Backpressure: write held stable while mem_ready is low.
        do_reset();
        mem_ready = 1'b0;
        strobe(8'd0, 7'd0, 3'd1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (mem_we) seen = 1'b1;
            else tick(1);
        end
        check("bp_we_seen", seen, 1);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (!(mem_we && mem_addr == 15'd0 && mem_data == 3'd1)) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        check("bp_no_accept", acc_addr.size(), 0);
        mem_ready = 1'b1;
        tick(1);
        check("bp_we_drop", mem_we, 0);
        tick(3);
        check("bp_accepts", acc_addr.size(), 1);

        // Overflow: six strobes into a stalled sink.
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) strobe(8'(i), 7'd0, 3'd2);
        tick(2);
        check("ovf_level", fifo_level, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_drop", drop_count, 2);
        mem_ready = 1'b1;
        tick(8);
        check("ovf_count", acc_addr.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("ovf_order%0d", i), acc_at(i), 32'(i));
        if (acc_cyc.size() == 4) check("ovf_b2b", acc_cyc[3] - acc_cyc[0], 3);
        else check("ovf_b2b", acc_cyc.size(), 4);
        check("ovf_sticky", overflow, 1);
        check("ovf_level_end", fifo_level, 0);

        // Bounds: edge coordinates rejected, last in-range pixel accepted.
        do_reset();
        strobe(8'd160, 7'd0, 3'd7);
        strobe(8'd0, 7'd120, 3'd7);
        tick(4);
        check("bnd_drop", drop_count, 2);
        check("bnd_ovf", overflow, 0);
        check("bnd_no_write", acc_addr.size(), 0);
        strobe(8'd159, 7'd119, 3'd5);
        tick(4);
        check("bnd_corner", acc_at(0), 19199);
        check("bnd_drop_keep", drop_count, 2);

        // Reset asserted between edges while writes are pending.
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) strobe(8'(10 + i), 7'd1, 3'd3);
        tick(2);
        check("rmd_level_pre", fifo_level, 3);
        check("rmd_we_pre", mem_we, 1);
        #2;
        Reset = 1'b0;
        #1;
        check("rmd_we", mem_we, 0);
        check("rmd_level", fifo_level, 0);
        check("rmd_busy", busy, 0);
        tick(1);
        Reset     = 1'b1;
        mem_ready = 1'b1;
        acc_addr.delete();
        acc_cyc.delete();
        tick(10);
        check("rmd_no_stale", acc_addr.size(), 0);

        // Strobe already high at reset release counts on the first edge.
        Reset        = 1'b0;
        paint_x_co   = 8'd1;
        paint_y_co   = 7'd1;
        color        = 3'd2;
        print_enable = 1'b1;
        tick(1);
        Reset = 1'b1;
        acc_addr.delete();
        acc_cyc.delete();
        tick(3);
        print_enable = 1'b0;
        tick(4);
        check("rel_count", acc_addr.size(), 1);
        check("rel_addr", acc_at(0), 161);

        // Drop counter saturation.
        do_reset();
        for (int i = 0; i < 300; i++) strobe(8'd200, 7'd0, 3'd0);
        tick(2);
        check("sat_drop", drop_count, 255);
        check("sat_ovf", overflow, 0);
        check("sat_no_write", acc_addr.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
